sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Controller sharing one single-port synchronous SRAM macro (one RW port, 1-cycle read latency, 512x16) between a write requester and a read requester. Round-robin arbitration, valid/ready handshakes on both request ports and the read-response port, and buffering that absorbs response backpressure. Sits directly in front of the generated `_ext` memory wrapper; a macro selects whether the array is zero-filled after reset.

## Interface
Parameters:
- ADDR_W, 9, SRAM address width
- DATA_W, 16, SRAM data width
- DEPTH, 512, entries; must equal 2**ADDR_W

Ports:
- clock  in  1  single clock; all state on rising edge
- reset_n  in  1  synchronous, active-low reset
- wr_valid  in  1  write request present
- wr_ready  out  1  write accepted this cycle when wr_valid & wr_ready
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rd_valid  in  1  read request present
- rd_ready  out  1  read accepted this cycle when rd_valid & rd_ready
- rd_addr  in  ADDR_W  read address
- rsp_valid  out  1  read data available
- rsp_ready  in  1  consumer takes rsp_data
- rsp_data  out  DATA_W  read data
- init_done  out  1  high once the controller accepts requests
- sram_en  out  1  to RW0_en
- sram_wmode  out  1  to RW0_wmode (1 = write)
- sram_addr  out  ADDR_W  to RW0_addr
- sram_wdata  out  DATA_W  to RW0_wdata
- sram_rdata  in  DATA_W  from RW0_rdata

## Operation
- FSM states: INIT (zero-fill walk), RUN. Reset enters INIT when the macro is defined, else RUN.
- At most one SRAM access per cycle; sram_en = accepted read or write (or INIT write).
- Read eligibility: rd_elig = RUN & !hold_valid & !(inflight & !rsp_ready).
- Write eligibility: wr_elig = RUN.
- Arbitration, only when both are valid and eligible: priority bit `prio` (0 = write first, reset 0). The winner is taken; prio flips to favour the loser. Without contention the sole valid, eligible requester is granted and prio is unchanged.
- wr_ready/rd_ready are combinational grants, independent of the other side's valid except through arbitration.
- Response path (sub-module):
  - inflight set the cycle after a read grant.
  - rsp_data = inflight ? sram_rdata : hold_q.
  - rsp_valid = inflight | hold_valid.
  - If inflight & !rsp_ready: hold_q <= sram_rdata, hold_valid <= 1. The capture is required because a later write to the same address changes sram_rdata.
  - hold_valid clears on rsp_ready.
- Response ordering equals request order; at most one response is outstanding.

## Timing
- Reset values: wr_ready 0, rd_ready 0, rsp_valid 0, rsp_data 0 (hold_q 0), init_done 0 when the macro is defined (1 when not), sram_en 0, sram_wmode 0, sram_addr 0, sram_wdata 0.
- Read latency: grant in cycle N -> rsp_valid in N+1 with data from the array state at edge N.
- Back-to-back reads at full rate while rsp_ready = 1.
- Write is committed at the edge ending the grant cycle. A read granted in N+1 to the same address returns the new data.
- Backpressure: with rsp_ready = 0, at most one response is held; further reads stall; writes keep flowing.
- reset_n low mid-operation: inflight, hold_valid, prio and the INIT counter clear at that edge; the in-flight response is discarded; INIT restarts at address 0.

## Configuration
- SRAM_INIT_CLEAR_EN defined:
  - After reset the FSM stays in INIT for DEPTH cycles, writing 0 to addresses 0..DEPTH-1 (sram_en = 1, sram_wmode = 1).
  - wr_ready = rd_ready = 0 during INIT.
  - Enters RUN after the write to DEPTH-1; init_done rises the first RUN cycle (cycle DEPTH after reset release).
- Not defined: no INIT state; RUN from the first cycle after reset; init_done = 1 from reset; array contents undefined until written.

## Structure
- Package sram_arb_pkg: ADDR_W/DATA_W/DEPTH defaults, state enum {INIT, RUN}, grant enum {GNT_NONE, GNT_WR, GNT_RD}.
- One sub-module: sram_rsp_buffer (inflight flag, hold register, rsp_valid/rsp_data mux, eligibility output).
- Arbiter, FSM and SRAM drive stay in the top.

## Test plan
- Init (macro on): release reset, wait for init_done (expect cycle 512); read 0x1FF -> rsp_data 0x0000; wr_ready = 0 throughout INIT.
- Write-then-read: write 0x0A5 = 0xBEEF in cycle N, read 0x0A5 in N+1 -> rsp_valid in N+2 with 0xBEEF.
- Contention: wr_valid and rd_valid held high 4 cycles from reset -> grants W, R, W, R; rsp_valid one cycle after each R grant.
- Backpressure: read 0x010 (holds 0x1234), rsp_ready = 0; next cycle write 0x010 = 0x5555 -> rsp_data stays 0x1234; rd_ready = 0 until rsp_ready = 1; then responses resume.
- Streaming: 8 consecutive reads with rsp_ready = 1 -> 8 responses on consecutive cycles, in order, no bubbles.
- Mid-op reset: reset_n low the cycle a read response is held -> next cycle rsp_valid = 0, init_done = 0 (macro on), INIT restarts at address 0.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared defaults and enumerations for the SRAM port arbiter.
//   SRAM_ADDR_W / SRAM_DATA_W / SRAM_DEPTH : default geometry of the 512x16 macro
//   state_e : controller state (INIT zero-fill walk, RUN normal service)
//   gnt_e   : per-cycle SRAM port owner
package sram_arb_pkg;

  localparam int unsigned SRAM_ADDR_W = 9;
  localparam int unsigned SRAM_DATA_W = 16;
  localparam int unsigned SRAM_DEPTH  = 512;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WR   = 2'd1,
    GNT_RD   = 2'd2
  } gnt_e;

endpackage : sram_arb_pkg

// File: rtl/sram_rsp_buffer.sv
// sram_rsp_buffer: read-response path for the single-port SRAM arbiter.
// Tracks the one outstanding read, presents the SRAM output directly while
// it is fresh and falls back to a one-entry hold register when the consumer
// stalls, so a later write cannot corrupt a response that was not yet taken.
//   clock, reset_n    : clock, synchronous active-low reset
//   rd_gnt_i          : a read owns the SRAM port this cycle
//   rsp_ready_i       : consumer accepts rsp_data_o
//   sram_rdata_i      : SRAM read data (valid the cycle after a read)
//   rsp_valid_o       : response available
//   rsp_data_o        : response data
//   rd_free_o         : path can take another read this cycle
module sram_rsp_buffer
  import sram_arb_pkg::*;
#(
  parameter int unsigned DATA_W = SRAM_DATA_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              rd_gnt_i,
  input  logic              rsp_ready_i,
  input  logic [DATA_W-1:0] sram_rdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              rd_free_o
);

  logic              inflight_q;
  logic              hold_valid_q;
  logic [DATA_W-1:0] hold_q;

  // Outstanding-read tracking and stall capture.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      inflight_q   <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_q       <= '0;
    end else begin
      inflight_q <= rd_gnt_i;
      if (inflight_q && !rsp_ready_i) begin
        // Data is only guaranteed on sram_rdata for this one cycle.
        hold_q       <= sram_rdata_i;
        hold_valid_q <= 1'b1;
      end else if (hold_valid_q && rsp_ready_i) begin
        hold_valid_q <= 1'b0;
      end
    end
  end

  assign rsp_valid_o = inflight_q | hold_valid_q;
  assign rsp_data_o  = inflight_q ? sram_rdata_i : hold_q;

  // A new read may issue only if its response will have somewhere to land.
  assign rd_free_o = !hold_valid_q && !(inflight_q && !rsp_ready_i);

endmodule : sram_rsp_buffer

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port synchronous SRAM (1-cycle read
// latency) between a write requester and a read requester with round-robin
// arbitration and a backpressure-tolerant read-response path.
// Build option: define SRAM_INIT_CLEAR_EN to zero-fill the whole array after
// reset before any request is accepted (init_done marks completion).
//   clock, reset_n                    : clock, synchronous active-low reset
//   wr_valid/wr_ready/wr_addr/wr_data : write request handshake
//   rd_valid/rd_ready/rd_addr         : read request handshake
//   rsp_valid/rsp_ready/rsp_data      : read response handshake
//   init_done                         : controller accepting requests
//   sram_en/wmode/addr/wdata/rdata    : RW port of the memory wrapper
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = SRAM_ADDR_W,
  parameter int unsigned DATA_W = SRAM_DATA_W,
  parameter int unsigned DEPTH  = SRAM_DEPTH
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              init_done,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  // Geometry guard: the zero-fill walk relies on the counter wrapping at DEPTH.
  if (DEPTH != (32'd1 << ADDR_W)) begin : g_depth_check
    $error("sram_port_arbiter: DEPTH must equal 2**ADDR_W");
  end

`ifdef SRAM_INIT_CLEAR_EN
  localparam state_e RST_STATE = INIT;
`else
  localparam state_e RST_STATE = RUN;
`endif

  state_e state_q;
  logic   prio_q;
  logic   prio_d;
  gnt_e   gnt;
  logic   run;
  logic   rd_free;
  logic   wr_req;
  logic   rd_req;
`ifdef SRAM_INIT_CLEAR_EN
  logic [ADDR_W-1:0] init_cnt_q;
`endif

  // Controller state, zero-fill counter and round-robin pointer.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= RST_STATE;
      prio_q     <= 1'b0;
`ifdef SRAM_INIT_CLEAR_EN
      init_cnt_q <= '0;
`endif
    end else begin
      prio_q <= prio_d;
`ifdef SRAM_INIT_CLEAR_EN
      if (state_q == INIT) begin
        init_cnt_q <= init_cnt_q + ADDR_W'(1);
        if (init_cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_q <= RUN;
        end
      end
`endif
    end
  end

  // Requests are only serviced in RUN and never while reset is asserted.
  assign run    = reset_n && (state_q == RUN);
  assign wr_req = wr_valid && run;
  assign rd_req = rd_valid && run && rd_free;

  // Round-robin: prio 0 favours write; the pointer moves only on contention.
  always_comb begin
    gnt    = GNT_NONE;
    prio_d = prio_q;
    if (wr_req && rd_req) begin
      if (prio_q) begin
        gnt    = GNT_RD;
        prio_d = 1'b0;
      end else begin
        gnt    = GNT_WR;
        prio_d = 1'b1;
      end
    end else if (wr_req) begin
      gnt = GNT_WR;
    end else if (rd_req) begin
      gnt = GNT_RD;
    end
  end

  assign wr_ready = (gnt == GNT_WR);
  assign rd_ready = (gnt == GNT_RD);

  // SRAM port drive: idle port parks at zero.
  always_comb begin
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
`ifdef SRAM_INIT_CLEAR_EN
    if (reset_n && (state_q == INIT)) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = init_cnt_q;
    end
`endif
    case (gnt)
      GNT_WR: begin
        sram_en    = 1'b1;
        sram_wmode = 1'b1;
        sram_addr  = wr_addr;
        sram_wdata = wr_data;
      end
      GNT_RD: begin
        sram_en   = 1'b1;
        sram_addr = rd_addr;
      end
      default: ;
    endcase
  end

  assign init_done = (state_q == RUN);

  sram_rsp_buffer #(
    .DATA_W (DATA_W)
  ) u_rsp_buffer (
    .clock        (clock),
    .reset_n      (reset_n),
    .rd_gnt_i     (gnt == GNT_RD),
    .rsp_ready_i  (rsp_ready),
    .sram_rdata_i (sram_rdata),
    .rsp_valid_o  (rsp_valid),
    .rsp_data_o   (rsp_data),
    .rd_free_o    (rd_free)
  );

endmodule : sram_port_arbiter

// File: tb/tb_sram_port_arbiter.sv
// Directed testbench for sram_port_arbiter with a behavioural 512x16 RW SRAM.
// The memory model mirrors write data onto rdata so a stalled response that
// is not captured is visibly overwritten.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_valid, wr_ready;
  logic [8:0]  wr_addr;
  logic [15:0] wr_data;
  logic        rd_valid, rd_ready;
  logic [8:0]  rd_addr;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_data;
  logic        init_done;
  logic        sram_en, sram_wmode;
  logic [8:0]  sram_addr;
  logic [15:0] sram_wdata;
  logic [15:0] sram_rdata;

  logic [15:0] mem [0:511];
  int n_vec = 0;
  int n_err = 0;

`ifdef SRAM_INIT_CLEAR_EN
  localparam logic INIT_AT_RST = 1'b0;
`else
  localparam logic INIT_AT_RST = 1'b1;
`endif

  always #5 clk = ~clk;

  sram_port_arbiter dut (
    .clock      (clk),
    .reset_n    (reset_n),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_addr    (rd_addr),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .init_done  (init_done),
    .sram_en    (sram_en),
    .sram_wmode (sram_wmode),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  // Single-port SRAM model, 1-cycle read latency, write-through output.
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_wmode) begin
        mem[sram_addr] <= sram_wdata;
        sram_rdata     <= sram_wdata;
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle();
    wr_valid = 1'b0;
    rd_valid = 1'b0;
  endtask

  task automatic wait_init();
    bit seen = 1'b0;
    for (int k = 0; k < 600 && !seen; k++) begin
      smp();
      if (init_done === 1'b1) seen = 1'b1;
      nxt();
    end
    n_vec++; if (seen !== 1'b1) begin n_err++; $display("FAIL wait_init init_done never rose"); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; rsp_ready = 1'b1;
    wr_valid = 1'b1; wr_addr = 9'h055; wr_data = 16'h1111;
    rd_valid = 1'b1; rd_addr = 9'h066;
    nxt(); nxt();
    smp();
    n_vec++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL rst_wr_ready got %b exp 0", wr_ready); end
    n_vec++; if (rd_ready !== 1'b0) begin n_err++; $display("FAIL rst_rd_ready got %b exp 0", rd_ready); end
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid); end
    n_vec++; if (rsp_data !== 16'h0000) begin n_err++; $display("FAIL rst_rsp_data got %h exp 0000", rsp_data); end
    n_vec++; if (init_done !== INIT_AT_RST) begin n_err++; $display("FAIL rst_init_done got %b exp %b", init_done, INIT_AT_RST); end
    n_vec++; if ({sram_en, sram_wmode} !== 2'b00) begin n_err++; $display("FAIL rst_sram_ctl got %b%b exp 00", sram_en, sram_wmode); end
    n_vec++; if (sram_addr !== 9'h000) begin n_err++; $display("FAIL rst_sram_addr got %h exp 000", sram_addr); end
    n_vec++; if (sram_wdata !== 16'h0000) begin n_err++; $display("FAIL rst_sram_wdata got %h exp 0000", sram_wdata); end
    nxt();
    reset_n = 1'b1;
  endtask

  task automatic test_init();
`ifdef SRAM_INIT_CLEAR_EN
    for (int k = 0; k < 512; k++) begin
      wr_valid = 1'b1; rd_valid = 1'b1;
      smp();
      n_vec++; if (init_done !== 1'b0) begin n_err++; $display("FAIL init_done_early cyc %0d got %b exp 0", k, init_done); end
      n_vec++; if ({wr_ready, rd_ready} !== 2'b00) begin n_err++; $display("FAIL init_ready cyc %0d got %b%b exp 00", k, wr_ready, rd_ready); end
      n_vec++; if ({sram_en, sram_wmode} !== 2'b11) begin n_err++; $display("FAIL init_sram_ctl cyc %0d got %b%b exp 11", k, sram_en, sram_wmode); end
      n_vec++; if (sram_addr !== 9'(k)) begin n_err++; $display("FAIL init_addr cyc %0d got %h exp %h", k, sram_addr, 9'(k)); end
      nxt();
    end
    idle();
    rd_valid = 1'b1; rd_addr = 9'h1FF;
    smp();
    n_vec++; if (init_done !== 1'b1) begin n_err++; $display("FAIL init_done_512 got %b exp 1", init_done); end
    n_vec++; if (rd_ready !== 1'b1) begin n_err++; $display("FAIL init_rd_1ff_ready got %b exp 1", rd_ready); end
    nxt();
    idle();
    smp();
    n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL init_rsp_valid got %b exp 1", rsp_valid); end
    n_vec++; if (rsp_data !== 16'h0000) begin n_err++; $display("FAIL init_rsp_1ff got %h exp 0000", rsp_data); end
    nxt();
`else
    idle();
    smp();
    n_vec++; if (init_done !== 1'b1) begin n_err++; $display("FAIL noinit_done got %b exp 1", init_done); end
    n_vec++; if (sram_en !== 1'b0) begin n_err++; $display("FAIL noinit_sram_en got %b exp 0", sram_en); end
    nxt();
`endif
  endtask

  task automatic test_contention();
    logic [1:0]  exp_rdy [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
    logic [15:0] wdat    [4] = '{16'hC0DE, 16'h7777, 16'h7777, 16'h7777};
    rsp_ready = 1'b1;
    wr_valid = 1'b1; wr_addr = 9'h033;
    rd_valid = 1'b1; rd_addr = 9'h033;
    for (int k = 0; k < 4; k++) begin
      wr_data = wdat[k];
      smp();
      n_vec++; if ({wr_ready, rd_ready} !== exp_rdy[k]) begin n_err++; $display("FAIL cont_grant cyc %0d got %b%b exp %b", k, wr_ready, rd_ready, exp_rdy[k]); end
      n_vec++; if (rsp_valid !== (k == 2)) begin n_err++; $display("FAIL cont_rsp_valid cyc %0d got %b exp %b", k, rsp_valid, (k == 2)); end
      if (k == 2) begin
        n_vec++; if (rsp_data !== 16'hC0DE) begin n_err++; $display("FAIL cont_rsp_data1 got %h exp c0de", rsp_data); end
      end
      nxt();
    end
    idle();
    smp();
    n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL cont_rsp_valid2 got %b exp 1", rsp_valid); end
    n_vec++; if (rsp_data !== 16'h7777) begin n_err++; $display("FAIL cont_rsp_data2 got %h exp 7777", rsp_data); end
    nxt();
  endtask

  task automatic test_write_read();
    wr_valid = 1'b1; wr_addr = 9'h0A5; wr_data = 16'hBEEF;
    smp();
    n_vec++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL wr_ready got %b exp 1", wr_ready); end
    n_vec++; if ({sram_en, sram_wmode, sram_addr, sram_wdata} !== {2'b11, 9'h0A5, 16'hBEEF}) begin n_err++; $display("FAIL wr_sram_drive got %b%b %h %h exp 11 0a5 beef", sram_en, sram_wmode, sram_addr, sram_wdata); end
    nxt();
    wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 9'h0A5;
    smp();
    n_vec++; if ({rd_ready, sram_wmode, rsp_valid} !== 3'b100) begin n_err++; $display("FAIL rd_issue got %b%b%b exp 100", rd_ready, sram_wmode, rsp_valid); end
    nxt();
    idle();
    smp();
    n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL wrrd_rsp_valid got %b exp 1", rsp_valid); end
    n_vec++; if (rsp_data !== 16'hBEEF) begin n_err++; $display("FAIL wrrd_rsp_data got %h exp beef", rsp_data); end
    nxt();
    smp();
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL wrrd_rsp_done got %b exp 0", rsp_valid); end
    nxt();
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b1;
    wr_valid = 1'b1; wr_addr = 9'h010; wr_data = 16'h1234;
    nxt();
    wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 9'h010; rsp_ready = 1'b0;
    smp();
    n_vec++; if (rd_ready !== 1'b1) begin n_err++; $display("FAIL bp_rd_first got %b exp 1", rd_ready); end
    nxt();
    wr_valid = 1'b1; wr_addr = 9'h010; wr_data = 16'h5555;
    smp();
    n_vec++; if ({wr_ready, rd_ready} !== 2'b10) begin n_err++; $display("FAIL bp_wr_flow got %b%b exp 10", wr_ready, rd_ready); end
    n_vec++; if (rsp_data !== 16'h1234) begin n_err++; $display("FAIL bp_rsp_fresh got %h exp 1234", rsp_data); end
    nxt();
    wr_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rsp_ready = (k == 2);
      smp();
      n_vec++; if ({rsp_valid, rd_ready} !== 2'b10) begin n_err++; $display("FAIL bp_stall cyc %0d got %b%b exp 10", k, rsp_valid, rd_ready); end
      n_vec++; if (rsp_data !== 16'h1234) begin n_err++; $display("FAIL bp_hold_data cyc %0d got %h exp 1234", k, rsp_data); end
      nxt();
    end
    smp();
    n_vec++; if ({rd_ready, rsp_valid} !== 2'b10) begin n_err++; $display("FAIL bp_resume got %b%b exp 10", rd_ready, rsp_valid); end
    nxt();
    idle();
    smp();
    n_vec++; if (rsp_data !== 16'h5555 || rsp_valid !== 1'b1) begin n_err++; $display("FAIL bp_new_data got %b %h exp 1 5555", rsp_valid, rsp_data); end
    nxt();
  endtask

  task automatic test_streaming();
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wr_valid = 1'b1; wr_addr = 9'h100 + 9'(k); wr_data = 16'hA000 + 16'(k);
      nxt();
    end
    wr_valid = 1'b0;
    for (int k = 0; k < 9; k++) begin
      rd_valid = (k < 8); rd_addr = 9'h100 + 9'(k);
      smp();
      if (k < 8) begin
        n_vec++; if (rd_ready !== 1'b1) begin n_err++; $display("FAIL stream_rd_ready cyc %0d got %b exp 1", k, rd_ready); end
      end
      if (k > 0) begin
        n_vec++; if (rsp_valid !== 1'b1 || rsp_data !== 16'hA000 + 16'(k - 1)) begin n_err++; $display("FAIL stream_rsp cyc %0d got %b %h exp 1 %h", k, rsp_valid, rsp_data, 16'hA000 + 16'(k - 1)); end
      end
      nxt();
    end
    idle();
    smp();
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL stream_end got %b exp 0", rsp_valid); end
    nxt();
  endtask

  task automatic test_midop_reset();
    rsp_ready = 1'b1;
    wr_valid = 1'b1; wr_addr = 9'h020; wr_data = 16'h4242;
    rd_valid = 1'b1; rd_addr = 9'h021;
    smp();
    n_vec++; if ({wr_ready, rd_ready} !== 2'b10) begin n_err++; $display("FAIL mid_pre_cont got %b%b exp 10", wr_ready, rd_ready); end
    nxt();
    wr_valid = 1'b0; rd_addr = 9'h020; rsp_ready = 1'b0;
    nxt();
    rd_valid = 1'b0;
    nxt();
    reset_n = 1'b0;
    smp();
    n_vec++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h4242) begin n_err++; $display("FAIL mid_held got %b %h exp 1 4242", rsp_valid, rsp_data); end
    nxt();
    reset_n = 1'b1; rsp_ready = 1'b1;
    smp();
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL mid_rsp_drop got %b exp 0", rsp_valid); end
    n_vec++; if (init_done !== INIT_AT_RST) begin n_err++; $display("FAIL mid_init_done got %b exp %b", init_done, INIT_AT_RST); end
`ifdef SRAM_INIT_CLEAR_EN
    n_vec++; if (sram_addr !== 9'h000 || sram_en !== 1'b1) begin n_err++; $display("FAIL mid_init_addr0 got %b %h exp 1 000", sram_en, sram_addr); end
    nxt();
    smp();
    n_vec++; if (sram_addr !== 9'h001) begin n_err++; $display("FAIL mid_init_addr1 got %h exp 001", sram_addr); end
    nxt();
    wait_init();
`else
    nxt();
`endif
    wr_valid = 1'b1; wr_addr = 9'h022; wr_data = 16'h0001;
    rd_valid = 1'b1; rd_addr = 9'h020;
    smp();
    n_vec++; if ({wr_ready, rd_ready} !== 2'b10) begin n_err++; $display("FAIL mid_prio_clear got %b%b exp 10", wr_ready, rd_ready); end
    nxt();
    idle();
    nxt();
  endtask

  initial begin
    reset_n = 1'b0; rsp_ready = 1'b1;
    wr_valid = 1'b0; rd_valid = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    test_reset();
    test_init();
    test_contention();
    test_write_read();
    test_backpressure();
    test_streaming();
    test_midop_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_sram_port_arbiter
